// File: rtl/sect409r1_pt_unload_if.sv
// Word-stream bus carrying unloaded sect409r1 results to a narrow host sink.
// The master presents words and the slave accepts them with out_ready.
interface sect409r1_pt_unload_if #(
    parameter int DW = 32
);
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/sect409r1_pt_unload.sv
// Captures the affine (x, y) result on each rising edge of the multiplier's done
// and streams it out LSW first, x before y, over a valid/ready word bus.
module sect409r1_pt_unload #(
    parameter  int DW = 32,
    localparam int M  = 409
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  done,
    input  logic [M-1:0]          x,
    input  logic [M-1:0]          y,
    sect409r1_pt_unload_if.master ob,
    output logic                  busy,
    output logic                  ovf
);
    localparam int NW    = (M + DW - 1) / DW;
    localparam int WORDS = 2 * NW;
    localparam int HW    = NW * DW;
    localparam int BW    = 2 * HW;
    localparam int IW    = $clog2(WORDS);

    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);
    localparam logic [IW-1:0] PEN  = IW'(WORDS - 2);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t        state;
    logic          done_q;
    logic [IW-1:0] idx;
    logic [BW-1:0] buffer;

    logic          rise;
    logic          hs;
    logic [BW-1:0] capture;

    assign rise    = done & ~done_q;
    assign hs      = ob.out_valid & ob.out_ready;
    assign capture = {HW'(y), HW'(x)};

    // The buffer shifts right one word per handshake, so the current word is
    // always the low slice and a fully drained buffer reads as zero.
    assign ob.out_data = buffer[DW-1:0];

    // NOTE: all state below is sequential and uses non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            state        <= IDLE;
            done_q       <= 1'b0;
            idx          <= '0;
            // NOTE: the wide buffer is reset deliberately so out_data reads 0
            // after reset/clr and no stale result can leak onto the bus.
            buffer       <= '0;
            ob.out_valid <= 1'b0;
            ob.out_last  <= 1'b0;
            busy         <= 1'b0;
            ovf          <= 1'b0;
        end else begin
            done_q <= done;
            unique case (state)
                IDLE: begin
                    if (rise) begin
                        state        <= SEND;
                        buffer       <= capture;
                        idx          <= '0;
                        ob.out_valid <= 1'b1;
                        ob.out_last  <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                SEND: begin
                    if (hs && idx == LAST) begin
                        idx         <= '0;
                        ob.out_last <= 1'b0;
                        if (rise) begin
                            // Back-to-back result: reload without a bubble.
                            buffer <= capture;
                        end else begin
                            state        <= IDLE;
                            buffer       <= buffer >> DW;
                            ob.out_valid <= 1'b0;
                            busy         <= 1'b0;
                        end
                    end else begin
                        if (hs) begin
                            buffer      <= buffer >> DW;
                            idx         <= idx + 1'b1;
                            ob.out_last <= (idx == PEN);
                        end
                        if (rise) begin
                            ovf <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sect409r1_pt_unload.sv
// Scoreboard bench for sect409r1_pt_unload: stimulus pushes expected words,
// a negedge monitor pops and compares every accepted word.
module tb_sect409r1_pt_unload;
    localparam int DW    = 32;
    localparam int M     = 409;
    localparam int NW    = 13;
    localparam int WORDS = 26;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         clr   = 1'b0;
    logic         done  = 1'b0;
    logic [M-1:0] x     = '0;
    logic [M-1:0] y     = '0;
    logic         busy;
    logic         ovf;

    sect409r1_pt_unload_if #(.DW(DW)) bus ();

    sect409r1_pt_unload #(.DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .done  (done),
        .x     (x),
        .y     (y),
        .ob    (bus),
        .busy  (busy),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    logic [DW:0] sb[$];
    int total  = 0;
    int bad    = 0;
    int hs_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] word_of(input logic [M-1:0] v, input int k);
        logic [NW*DW-1:0] ve;
        ve = {{(NW*DW-M){1'b0}}, v};
        return ve[k*DW +: DW];
    endfunction

    function automatic logic [M-1:0] mk(input logic [31:0] s);
        logic [NW*DW-1:0] v;
        for (int k = 0; k < NW; k++) v[k*DW +: DW] = s + 32'(k) * 32'h0101_0101;
        return v[M-1:0];
    endfunction

    task automatic push_result(input logic [M-1:0] vx, input logic [M-1:0] vy);
        for (int k = 0; k < WORDS; k++)
            sb.push_back({1'(k == WORDS-1), (k < NW) ? word_of(vx, k) : word_of(vy, k-NW)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic wait_size(input string name, input int n);
        int c = 0;
        while (sb.size() != n && c < 200) begin
            tick();
            c++;
        end
        check(name, 64'(sb.size()), 64'(n));
    endtask

    // Waits for the expected queue to empty; busy must already be low then.
    task automatic drain(input string name);
        wait_size({name, "_drained"}, 0);
        check({name, "_busy_low"}, busy, 1'b0);
        check({name, "_valid_low"}, bus.out_valid, 1'b0);
    endtask

    // Monitor: stall stability and scoreboard comparison.
    logic          stall_prev = 1'b0;
    logic [DW:0]   prev_word  = '0;
    initial begin
        logic [DW:0] exp_w;
        forever begin
            @(negedge clk);
            if (!rst_n || clr) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_valid_held", bus.out_valid, 1'b1);
                    check("stall_word_stable", {bus.out_last, bus.out_data}, prev_word);
                end
                if (bus.out_valid && bus.out_ready) begin
                    check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                    if (sb.size() != 0) begin
                        exp_w = sb.pop_front();
                        check("stream_word", {bus.out_last, bus.out_data}, exp_w);
                        hs_cnt++;
                    end
                end
                stall_prev = bus.out_valid & ~bus.out_ready;
                prev_word  = {bus.out_last, bus.out_data};
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0;
        int c;
        bus.out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_last", bus.out_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_data", bus.out_data, 32'h0);
        rst_n = 1'b1;
        tick();

        // 1: x=1, y=2, ready held high; hand-computed words
        x = 409'h1;
        y = 409'h2;
        for (int k = 0; k < WORDS; k++)
            sb.push_back({1'(k == 25), (k == 0) ? 32'h1 : (k == 13) ? 32'h2 : 32'h0});
        done = 1'b1;
        check("t1_valid_before", bus.out_valid, 1'b0);
        tick();
        check("t1_valid_latency", bus.out_valid, 1'b1);
        check("t1_busy", busy, 1'b1);
        done = 1'b0;
        drain("t1");

        // 2: all ones, ready pattern 1,0,0,...
        x = '1;
        y = '1;
        for (int k = 0; k < WORDS; k++)
            sb.push_back({1'(k == 25), (k == 12 || k == 25) ? 32'h01FF_FFFF : 32'hFFFF_FFFF});
        h0 = hs_cnt;
        bus.out_ready = 1'b0;
        pulse_done();
        c = 0;
        while (sb.size() != 0 && c < 300) begin
            bus.out_ready = (c % 3 == 0);
            tick();
            c++;
        end
        check("t2_handshakes", 64'(hs_cnt - h0), 64'd26);
        check("t2_busy_low", busy, 1'b0);
        bus.out_ready = 1'b1;
        tick();

        // 3: overflow at word 5, then clr
        x = mk(32'h1000_0001);
        y = mk(32'h2000_0002);
        push_result(x, y);
        pulse_done();
        wait_size("t3_reach_w5", 21);
        x = mk(32'h3000_0003);
        y = mk(32'h4000_0004);
        done = 1'b1;
        tick();
        check("t3_ovf_set", ovf, 1'b1);
        done = 1'b0;
        drain("t3");
        repeat (5) tick();
        check("t3_no_second", bus.out_valid, 1'b0);
        check("t3_ovf_sticky", ovf, 1'b1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t3_ovf_clr", ovf, 1'b0);

        // 4: back-to-back rise on last-word acceptance
        x = mk(32'h5A00_0010);
        y = mk(32'h6B00_0020);
        push_result(x, y);
        pulse_done();
        wait_size("t4_reach_w25", 1);
        check("t4_last_present", bus.out_last, 1'b1);
        x = mk(32'h7C00_0030);
        y = mk(32'h8D00_0040);
        push_result(x, y);
        done = 1'b1;
        tick();
        check("t4_valid_stays", bus.out_valid, 1'b1);
        check("t4_ovf_zero", ovf, 1'b0);
        done = 1'b0;
        drain("t4");
        check("t4_ovf_end", ovf, 1'b0);

        // 5: reset mid-stream at word 10
        x = mk(32'h9E00_0050);
        y = mk(32'hAF00_0060);
        push_result(x, y);
        pulse_done();
        wait_size("t5_reach_w10", 16);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sb.delete();
        check("t5_valid", bus.out_valid, 1'b0);
        check("t5_busy", busy, 1'b0);
        check("t5_last", bus.out_last, 1'b0);
        check("t5_data", bus.out_data, 32'h0);
        tick();
        x = mk(32'hB000_0070);
        y = mk(32'hC100_0080);
        push_result(x, y);
        pulse_done();
        drain("t5");

        // 6: done held high for 40 cycles
        x = mk(32'hD200_0090);
        y = mk(32'hE300_00A0);
        push_result(x, y);
        done = 1'b1;
        repeat (40) tick();
        check("t6_ovf", ovf, 1'b0);
        check("t6_one_stream", 64'(sb.size()), 64'd0);
        check("t6_busy", busy, 1'b0);
        done = 1'b0;
        tick();
        x = mk(32'hF400_00B0);
        y = mk(32'h0500_00C0);
        push_result(x, y);
        pulse_done();
        drain("t6b");

        repeat (3) tick();
        check("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
